// File: rtl/decode_issue_buf_pkg.sv
// decode_issue_buf_pkg: shared widths, decoded bundle layout and buffer FSM states
package decode_issue_buf_pkg;
    localparam int ADDR_W    = 32;
    localparam int DEC_W_DEF = 64;
    typedef struct packed {
        logic [10:0] command;
        logic [3:0]  unit;
        logic [31:0] imm;
        logic        jump_;
        logic        br_;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
    } DecBundle_t;
    typedef enum logic {DBUF_RUN, DBUF_FLUSH} DecBufState_t;
endpackage

// File: rtl/decode_issue_buf_if.sv
// decode_issue_buf_if: decoder-side, issue-side and flow-control signals of the decode buffer
interface decode_issue_buf_if
    import decode_issue_buf_pkg::*;
#(
    parameter int ADDR  = ADDR_W,
    parameter int DEC_W = DEC_W_DEF,
    parameter int DEPTH = 4
);
    logic                   in_e_;
    logic [ADDR-1:0]        in_pc;
    logic [DEC_W-1:0]       in_dec;
    logic                   dec_flush_;
    logic                   is_full;
    logic                   stall;
    logic                   out_e_;
    logic [ADDR-1:0]        out_pc;
    logic [DEC_W-1:0]       out_dec;
    logic [$clog2(DEPTH):0] occ;
    modport master (output in_e_, in_pc, in_dec, dec_flush_, is_full,
                    input  stall, out_e_, out_pc, out_dec, occ);
    modport slave  (input  in_e_, in_pc, in_dec, dec_flush_, is_full,
                    output stall, out_e_, out_pc, out_dec, occ);
endinterface

// File: rtl/decode_issue_buf_ram.sv
// decode_issue_buf_ram: entry storage with one write port and one asynchronous read port
module decode_issue_buf_ram #(
    parameter int W     = 96,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    // write the accepted entry; whole array clears on reset
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/decode_issue_buf.sv
// decode_issue_buf: elastic decode-to-issue buffer with full stall and flush recovery window
module decode_issue_buf
    import decode_issue_buf_pkg::*;
#(
    parameter int ADDR      = ADDR_W,
    parameter int DEC_W     = DEC_W_DEF,
    parameter int DEPTH     = 4,
    parameter int FLUSH_LAT = 2
) (
    input logic               clk,
    input logic               reset_,
    decode_issue_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int CW = $clog2(FLUSH_LAT + 1);

    DecBufState_t        state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]       occ_q, occ_d;
    logic                stall_q, stall_d;
    logic                flush, push, pop;
    logic [ADDR+DEC_W-1:0] rd_data;

    decode_issue_buf_ram #(.W(ADDR + DEC_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .reset_  (reset_),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.in_pc, bus.in_dec}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // flush overrides everything; otherwise count down recovery or move entries
    always_comb begin
        flush    = !bus.dec_flush_;
        push     = state_q == DBUF_RUN && !bus.in_e_ && !stall_q && !flush;
        pop      = occ_q != '0 && !bus.is_full && !flush;
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        occ_d    = occ_q + OW'(push) - OW'(pop);
        if (flush) begin
            state_d  = DBUF_FLUSH;
            cnt_d    = CW'(FLUSH_LAT - 1);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else if (state_q == DBUF_FLUSH) begin
            state_d = cnt_q == '0 ? DBUF_RUN : DBUF_FLUSH;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - CW'(1);
        end
        stall_d = state_d == DBUF_FLUSH || occ_d == OW'(DEPTH);
    end

    // state, pointers, occupancy and registered stall
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= DBUF_RUN;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.stall   = stall_q;
    assign bus.occ     = occ_q;
    assign bus.out_e_  = occ_q == '0;
    assign bus.out_pc  = bus.out_e_ ? '0 : rd_data[ADDR+DEC_W-1:DEC_W];
    assign bus.out_dec = bus.out_e_ ? '0 : rd_data[DEC_W-1:0];
endmodule

// File: tb/tb_decode_issue_buf.sv
// tb_decode_issue_buf: directed and randomized checks of decode_issue_buf against a queue model
module tb_decode_issue_buf;
    localparam int DEPTH     = 4;
    localparam int FLUSH_LAT = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] dec;
    } ent_t;

    logic clk = 0;
    logic reset_ = 0;
    int   cmp = 0;
    int   errs = 0;
    ent_t mq[$];
    int   m_fl = 0;
    bit   m_stall = 0;

    decode_issue_buf_if bus ();
    decode_issue_buf #(.DEPTH(DEPTH), .FLUSH_LAT(FLUSH_LAT)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // advance the reference queue model by one clock using the inputs present now
    task automatic tick();
        bit   fl   = !bus.dec_flush_;
        bit   pop  = mq.size() != 0 && !bus.is_full;
        bit   push = !bus.in_e_ && !m_stall;
        ent_t e    = '{bus.in_pc, bus.in_dec};
        if (fl) begin
            mq.delete();
            m_fl = FLUSH_LAT;
        end else if (m_fl > 0) begin
            m_fl--;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        m_stall = m_fl > 0 || mq.size() == DEPTH;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_fl = 0;
        m_stall = 0;
    endtask

    task automatic test_reset();
        bus.in_e_ = 1; bus.in_pc = 0; bus.in_dec = 0; bus.dec_flush_ = 1; bus.is_full = 0;
        reset_ = 0;
        @(posedge clk); @(posedge clk); #1;
        cmp++; if (bus.stall !== 1'b0 || bus.out_e_ !== 1'b1 || bus.out_pc !== 0 || bus.out_dec !== 0 || bus.occ !== 0) begin
            errs++; $display("FAIL reset_init: stall=%b out_e_=%b pc=%h occ=%0d, want 0 1 0 0", bus.stall, bus.out_e_, bus.out_pc, bus.occ);
        end
        reset_ = 1;
        model_reset();
        bus.is_full = 1;
        for (int i = 0; i < 3; i++) begin
            bus.in_e_ = 0; bus.in_pc = 32'h500 + 32'(i); bus.in_dec = {$urandom, $urandom};
            tick();
        end
        bus.in_e_ = 1;
        cmp++; if (bus.occ !== 3) begin errs++; $display("FAIL reset_prefill: occ=%0d want 3", bus.occ); end
        reset_ = 0;
        #1;
        cmp++; if (bus.stall !== 1'b0 || bus.out_e_ !== 1'b1 || bus.out_pc !== 0 || bus.occ !== 0) begin
            errs++; $display("FAIL reset_mid: stall=%b out_e_=%b pc=%h occ=%0d, want 0 1 0 0", bus.stall, bus.out_e_, bus.out_pc, bus.occ);
        end
        model_reset();
        #1 reset_ = 1;
        bus.is_full = 0;
    endtask

    task automatic test_single();
        bus.in_e_ = 0; bus.in_pc = 32'h100; bus.in_dec = 64'h1234_5678_9abc_def0; bus.is_full = 0;
        tick();
        bus.in_e_ = 1;
        cmp++; if (bus.out_e_ !== 1'b0 || bus.out_pc !== 32'h100) begin
            errs++; $display("FAIL single_out: out_e_=%b pc=%h, want 0 100", bus.out_e_, bus.out_pc);
        end
        cmp++; if (bus.out_dec !== 64'h1234_5678_9abc_def0) begin
            errs++; $display("FAIL single_dec: dec=%h want 123456789abcdef0", bus.out_dec);
        end
        tick();
        cmp++; if (bus.out_e_ !== 1'b1 || bus.out_pc !== 0) begin
            errs++; $display("FAIL single_pop: out_e_=%b pc=%h, want 1 0", bus.out_e_, bus.out_pc);
        end
    endtask

    task automatic test_fill();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h8; exp_pc[1] = 32'hC; exp_pc[2] = 32'h10;
        bus.is_full = 1;
        for (int i = 0; i < 4; i++) begin
            bus.in_e_ = 0; bus.in_pc = 32'(i * 4);
            tick();
        end
        cmp++; if (bus.occ !== 4 || bus.stall !== 1'b1) begin
            errs++; $display("FAIL fill_full: occ=%0d stall=%b, want 4 1", bus.occ, bus.stall);
        end
        bus.in_pc = 32'h10;
        tick();
        cmp++; if (bus.occ !== 4 || bus.stall !== 1'b1) begin
            errs++; $display("FAIL fill_hold: occ=%0d stall=%b, want 4 1", bus.occ, bus.stall);
        end
        bus.is_full = 0;
        cmp++; if (bus.out_pc !== 32'h0) begin errs++; $display("FAIL fill_head0: pc=%h want 0", bus.out_pc); end
        tick();
        cmp++; if (bus.stall !== 1'b0 || bus.out_pc !== 32'h4) begin
            errs++; $display("FAIL fill_release: stall=%b pc=%h, want 0 4", bus.stall, bus.out_pc);
        end
        tick();
        bus.in_e_ = 1;
        cmp++; if (bus.occ !== 3) begin errs++; $display("FAIL fill_fifth: occ=%0d want 3", bus.occ); end
        for (int i = 0; i < 3; i++) begin
            cmp++; if (bus.out_pc !== exp_pc[i]) begin
                errs++; $display("FAIL fill_order%0d: pc=%h want %h", i, bus.out_pc, exp_pc[i]);
            end
            tick();
        end
        cmp++; if (bus.out_e_ !== 1'b1) begin errs++; $display("FAIL fill_empty: out_e_=%b want 1", bus.out_e_); end
    endtask

    task automatic test_push_pop();
        bus.is_full = 1;
        for (int i = 0; i < 2; i++) begin
            bus.in_e_ = 0; bus.in_pc = $urandom; bus.in_dec = {$urandom, $urandom};
            tick();
        end
        bus.is_full = 0;
        for (int i = 0; i < 8; i++) begin
            bus.in_pc = $urandom; bus.in_dec = {$urandom, $urandom};
            tick();
            cmp++; if (bus.occ !== 2 || bus.out_pc !== mq[0].pc || bus.out_dec !== mq[0].dec) begin
                errs++; $display("FAIL pushpop%0d: occ=%0d pc=%h, want 2 %h", i, bus.occ, bus.out_pc, mq[0].pc);
            end
        end
        bus.in_e_ = 1;
        tick(); tick();
    endtask

    task automatic test_flush();
        bus.is_full = 1;
        for (int i = 0; i < 3; i++) begin
            bus.in_e_ = 0; bus.in_pc = 32'h300 + 32'(i);
            tick();
        end
        bus.dec_flush_ = 0; bus.in_e_ = 0; bus.in_pc = 32'hDEAD;
        tick();
        bus.dec_flush_ = 1; bus.in_pc = 32'h200; bus.is_full = 0;
        cmp++; if (bus.occ !== 0 || bus.out_e_ !== 1'b1 || bus.stall !== 1'b1) begin
            errs++; $display("FAIL flush_1: occ=%0d out_e_=%b stall=%b, want 0 1 1", bus.occ, bus.out_e_, bus.stall);
        end
        tick();
        cmp++; if (bus.stall !== 1'b1 || bus.out_e_ !== 1'b1) begin
            errs++; $display("FAIL flush_2: stall=%b out_e_=%b, want 1 1", bus.stall, bus.out_e_);
        end
        tick();
        cmp++; if (bus.stall !== 1'b0 || bus.out_e_ !== 1'b1) begin
            errs++; $display("FAIL flush_end: stall=%b out_e_=%b, want 0 1", bus.stall, bus.out_e_);
        end
        tick();
        bus.in_e_ = 1;
        cmp++; if (bus.out_e_ !== 1'b0 || bus.out_pc !== 32'h200) begin
            errs++; $display("FAIL flush_resume: out_e_=%b pc=%h, want 0 200", bus.out_e_, bus.out_pc);
        end
        tick();
        cmp++; if (bus.out_e_ !== 1'b1) begin errs++; $display("FAIL flush_drain: out_e_=%b want 1", bus.out_e_); end
    endtask

    task automatic test_back_to_back();
        bus.dec_flush_ = 0;
        tick();
        tick();
        bus.dec_flush_ = 1;
        cmp++; if (bus.stall !== 1'b1) begin errs++; $display("FAIL b2b_1: stall=%b want 1", bus.stall); end
        tick();
        cmp++; if (bus.stall !== 1'b1) begin errs++; $display("FAIL b2b_2: stall=%b want 1", bus.stall); end
        tick();
        cmp++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL b2b_end: stall=%b want 0", bus.stall); end
    endtask

    task automatic test_random();
        ent_t h;
        for (int i = 0; i < 400; i++) begin
            if (!m_stall) begin
                bus.in_e_  = $urandom_range(9) < 3;
                bus.in_pc  = $urandom;
                bus.in_dec = {$urandom, $urandom};
            end
            bus.is_full    = $urandom_range(1);
            bus.dec_flush_ = $urandom_range(24) != 0;
            tick();
            h = mq.size() != 0 ? mq[0] : '0;
            cmp++; if (bus.occ !== mq.size() || bus.stall !== m_stall || bus.out_e_ !== (mq.size() == 0) ||
                       bus.out_pc !== h.pc || bus.out_dec !== h.dec) begin
                errs++; $display("FAIL rand%0d: occ=%0d stall=%b out_e_=%b pc=%h dec=%h, want %0d %b %b %h %h",
                                 i, bus.occ, bus.stall, bus.out_e_, bus.out_pc, bus.out_dec,
                                 mq.size(), m_stall, mq.size() == 0, h.pc, h.dec);
            end
        end
        bus.in_e_ = 1; bus.dec_flush_ = 1; bus.is_full = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_push_pop();
        test_flush();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
